xfifo_sc: RTL and testbench
===========================

XFIFO_SC -- requirements
Module: xfifo_sc

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter dta_width, default 9'd8: data bus width in bits.
REQ-003 Parameter addr_width, default 9'd8: address width; depth DEPTH = 2^addr_width entries.
REQ-004 Parameter prog_thresh, default 9'd1: threshold for prog_empty and prog_full; legal range 0..DEPTH.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 din  input  dta_width  write data.
REQ-008 wr_en  input  1  write request.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 wr_ack  output  1  previous-cycle write accepted.
REQ-011 overflow  output  1  previous-cycle write rejected because the FIFO was full.
REQ-012 prog_full  output  1  free entries <= prog_thresh.
REQ-013 dout  output  dta_width  registered read data.
REQ-014 rd_en  input  1  read request.
REQ-015 empty  output  1  FIFO holds 0 entries.
REQ-016 valid  output  1  dout carries data read in the previous cycle.
REQ-017 underflow  output  1  previous-cycle read rejected because the FIFO was empty.
REQ-018 prog_empty  output  1  stored entries <= prog_thresh.

Function
REQ-019 Storage SHALL be a DEPTH x dta_width RAM with addr_width-bit write and read pointers that wrap modulo DEPTH; the occupancy count SHALL be addr_width+1 bits wide, range 0..DEPTH.
REQ-020 A write SHALL occur on an edge where wr_en=1 and full=0: store din at the write pointer and increment the write pointer.
REQ-021 A read SHALL occur on an edge where rd_en=1 and empty=0: load dout with the entry at the read pointer and increment the read pointer; read latency is 1 cycle.
REQ-022 dout SHALL hold its previous value on any edge without a read.
REQ-023 full and empty SHALL be evaluated before the edge: rd_en with full=1 reads; wr_en with full=1 is rejected even if a read occurs in the same cycle; rd_en with empty=1 is rejected even if a write occurs in the same cycle.
REQ-024 The count SHALL update per edge: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-025 The following flags SHALL be decoded combinationally from the registered count: empty = (count==0); full = (count==DEPTH); prog_empty = (count <= prog_thresh); prog_full = (count >= DEPTH - prog_thresh).
REQ-026 valid, underflow, wr_ack and overflow SHALL be registered, asserted for exactly one cycle after the qualifying edge: valid <= rd_en&~empty; underflow <= rd_en&empty; wr_ack <= wr_en&~full; overflow <= wr_en&full.
REQ-027 Rejected writes and reads SHALL NOT alter the RAM, the pointers, the count or dout.
REQ-028 The FIFO SHALL be first-word-first-out: data SHALL emerge in write order across pointer wrap-around.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, clear the pointers, count, dout, valid, underflow, wr_ack and overflow to 0.
REQ-030 The outputs SHALL then be empty=1, full=0, prog_empty=1, and prog_full=1 only if prog_thresh=DEPTH, otherwise 0.
REQ-031 RAM contents SHALL NOT be reset; reset mid-operation SHALL discard all stored entries.
REQ-032 The FIFO SHALL accept wr_en and rd_en on the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL use dta_width=8, addr_width=2 (DEPTH 4) and prog_thresh=1.
REQ-034 Reset then idle -> empty=1, prog_empty=1, full=0, prog_full=0, dout=0, and all strobes 0.
REQ-035 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> wr_ack=1 for each write; after the 1st write empty=0 and prog_empty=1; after the 2nd prog_empty=0; after the 3rd prog_full=1; after the 4th full=1.
REQ-036 Fifth write 0x55 while full -> overflow=1 and wr_ack=0 the next cycle; the count stays 4; later reads return 0x11,0x22,0x33,0x44 with valid=1 each cycle after rd_en.
REQ-037 rd_en while empty -> underflow=1 and valid=0 the next cycle, and dout is unchanged.
REQ-038 Simultaneous rd_en and wr_en while full -> the read returns the oldest entry, the write is rejected with overflow=1, and the count becomes 3; simultaneous rd_en and wr_en while empty -> the write is accepted, underflow=1, and the count becomes 1.
REQ-039 Stream 10 words with interleaved reads to force pointer wrap, and assert rst while holding 2 entries -> order is preserved across the wrap; on reset, flags and strobes clear immediately and the next read after reset gives underflow=1.

Source files
------------

// File: rtl/xfifo_sc.sv
// Single-clock synchronous FIFO with registered read data, handshake strobes
// and programmable almost-empty / almost-full flags decoded from the fill count.
module xfifo_sc #(
    parameter int unsigned dta_width   = 9'd8,
    parameter int unsigned addr_width  = 9'd8,
    parameter int unsigned prog_thresh = 9'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dta_width-1:0] din,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 wr_ack,
    output logic                 overflow,
    output logic                 prog_full,
    output logic [dta_width-1:0] dout,
    input  logic                 rd_en,
    output logic                 empty,
    output logic                 valid,
    output logic                 underflow,
    output logic                 prog_empty
);

    localparam int unsigned DEPTH = 1 << addr_width;
    localparam int unsigned CW    = addr_width + 1;

    logic [dta_width-1:0]  mem_q [DEPTH];
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [dta_width-1:0]  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_ok, rd_ok;

    // Status flags come straight from the registered count.
    assign empty      = (count_q == CW'(0));
    assign full       = (count_q == CW'(DEPTH));
    assign prog_empty = (count_q <= CW'(prog_thresh));
    assign prog_full  = (count_q >= CW'(DEPTH - prog_thresh));

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign underflow = underflow_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;

    always_comb begin
        wr_ok       = wr_en & ~full;
        rd_ok       = rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        valid_d     = rd_ok;
        underflow_d = rd_en & empty;
        wr_ack_d    = wr_ok;
        overflow_d  = wr_en & full;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + addr_width'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + addr_width'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        // Simultaneous accepted read and write leave the count unchanged.
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_xfifo_sc.sv
// Self-checking bench for xfifo_sc (DEPTH 4, prog_thresh 1) against a queue-based reference model.
module tb_xfifo_sc;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PT    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en, rd_en;
    logic          full, wr_ack, overflow, prog_full;
    logic [DW-1:0] dout;
    logic          empty, valid, underflow, prog_empty;

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a queue, plus expected registered outputs.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_udf, m_ack, m_ovf;

    xfifo_sc #(.dta_width(DW), .addr_width(AW), .prog_thresh(PT)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .wr_ack(wr_ack), .overflow(overflow), .prog_full(prog_full),
        .dout(dout), .rd_en(rd_en), .empty(empty), .valid(valid),
        .underflow(underflow), .prog_empty(prog_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        q.delete();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_udf   = 1'b0;
        m_ack   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle, then advance the model using pre-edge occupancy.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        bit mf, me;
        wr_en = w;
        rd_en = r;
        din   = d;
        mf = (q.size() == DEPTH);
        me = (q.size() == 0);
        @(posedge clk);
        #1;
        m_ack   = w && !mf;
        m_ovf   = w && mf;
        m_valid = r && !me;
        m_udf   = r && me;
        if (m_valid) m_dout = q.pop_front();
        if (m_ack) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 8'h00);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL reset_prog_empty got=%b exp=1", prog_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL reset_prog_full got=%b exp=0", prog_full); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if ({valid, underflow, wr_ack, overflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {valid, underflow, wr_ack, overflow});
        end
    endtask

    task automatic test_fill();
        logic [7:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, data[i]);
            checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL fill_wr_ack[%0d] got=%b exp=1", i, wr_ack); end
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
            checks++; if (prog_empty !== (i < 1)) begin errors++; $display("FAIL fill_prog_empty[%0d] got=%b exp=%b", i, prog_empty, i < 1); end
            checks++; if (prog_full !== (i >= 2)) begin errors++; $display("FAIL fill_prog_full[%0d] got=%b exp=%b", i, prog_full, i >= 2); end
            checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
        end
    endtask

    task automatic test_overflow_drain();
        logic [7:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycle(1'b1, 1'b0, 8'h55);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_overflow got=%b exp=1", overflow); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL ovf_wr_ack got=%b exp=0", wr_ack); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_count_full got=%b exp=1", full); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, valid); end
            checks++; if (dout !== data[i]) begin errors++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, data[i]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h00);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_underflow got=%b exp=1", underflow); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL udf_valid got=%b exp=0", valid); end
        checks++; if (dout !== 8'h44) begin errors++; $display("FAIL udf_dout got=%h exp=44", dout); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i));
        cycle(1'b1, 1'b1, 8'hEE);
        checks++; if (valid !== 1'b1 || dout !== 8'hA0) begin
            errors++; $display("FAIL simfull_read got valid=%b dout=%h exp valid=1 dout=a0", valid, dout);
        end
        checks++; if (overflow !== 1'b1 || wr_ack !== 1'b0) begin
            errors++; $display("FAIL simfull_write got ovf=%b ack=%b exp ovf=1 ack=0", overflow, wr_ack);
        end
        checks++; if ({full, prog_full, empty} !== 3'b010) begin
            errors++; $display("FAIL simfull_count3 got full/pf/empty=%b exp=010", {full, prog_full, empty});
        end
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++; if (dout !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL simfull_drain[%0d] got=%h exp=%h", i, dout, 8'hA0 + 8'(i)); end
        end
        cycle(1'b1, 1'b1, 8'h5A);
        checks++; if (underflow !== 1'b1 || valid !== 1'b0 || wr_ack !== 1'b1) begin
            errors++; $display("FAIL simempty_strobes got udf=%b valid=%b ack=%b exp 1 0 1", underflow, valid, wr_ack);
        end
        checks++; if ({empty, prog_empty} !== 2'b01) begin
            errors++; $display("FAIL simempty_count1 got empty/pe=%b exp=01", {empty, prog_empty});
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++; if (dout !== 8'h5A || empty !== 1'b1) begin
            errors++; $display("FAIL simempty_read got dout=%h empty=%b exp 5a 1", dout, empty);
        end
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i >= 2), 8'hC0 + 8'(i));
            if (m_valid) begin
                checks++; if (valid !== 1'b1 || dout !== m_dout) begin
                    errors++; $display("FAIL wrap_order[%0d] got valid=%b dout=%h exp 1 %h", i, valid, dout, m_dout);
                end
            end
        end
        checks++; if (q.size() != 2 || {empty, prog_empty} !== 2'b00) begin
            errors++; $display("FAIL wrap_hold2 got empty/pe=%b exp=00", {empty, prog_empty});
        end
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++; if ({empty, prog_empty, full, prog_full} !== 4'b1100) begin
            errors++; $display("FAIL async_rst_flags got=%b exp=1100", {empty, prog_empty, full, prog_full});
        end
        checks++; if ({valid, underflow, wr_ack, overflow} !== 4'b0000 || dout !== 8'h00) begin
            errors++; $display("FAIL async_rst_strobes got=%b dout=%h exp 0000 00", {valid, underflow, wr_ack, overflow}, dout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 1'b1, 8'h00);
        checks++; if (underflow !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_read got udf=%b valid=%b exp 1 0", underflow, valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
            checks++; if (dout !== m_dout || valid !== m_valid) begin
                errors++; $display("FAIL rand_read[%0d] got valid=%b dout=%h exp %b %h", n, valid, dout, m_valid, m_dout);
            end
            checks++; if ({wr_ack, overflow, underflow} !== {m_ack, m_ovf, m_udf}) begin
                errors++; $display("FAIL rand_strobes[%0d] got=%b exp=%b", n, {wr_ack, overflow, underflow}, {m_ack, m_ovf, m_udf});
            end
            checks++; if ({empty, full, prog_empty, prog_full} !==
                          {q.size() == 0, q.size() == DEPTH, q.size() <= PT, q.size() >= DEPTH - PT}) begin
                errors++; $display("FAIL rand_flags[%0d] got=%b occupancy=%0d", n, {empty, full, prog_empty, prog_full}, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_simultaneous();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
